// File: rtl/forward_layer_mac_if.sv
// Control, memory and result bus of the fully-connected layer engine.
// master = engine side, slave = environment (memories, sequencer, next layer).
interface forward_layer_mac_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int N_IN   = 784,
    parameter int N_OUT  = 16
) ();
    localparam int XA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int J_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic              start;
    logic              relu;
    logic              busy;
    logic              done;
    logic [XA_W-1:0]   x_addr;
    logic [DATA_W-1:0] x_data;
    logic [WA_W-1:0]   w_addr;
    logic [DATA_W-1:0] w_data;
    logic [J_W-1:0]    b_addr;
    logic [DATA_W-1:0] b_data;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [J_W-1:0]    out_idx;
    logic              sat_flag;

    modport master (
        input  start, relu, x_data, w_data, b_data,
        output busy, done, x_addr, w_addr, b_addr,
        output out_valid, out_data, out_idx, sat_flag
    );

    modport slave (
        output start, relu, x_data, w_data, b_data,
        input  busy, done, x_addr, w_addr, b_addr,
        input  out_valid, out_data, out_idx, sat_flag
    );
endinterface

// File: rtl/forward_layer_mac.sv
// Fully-connected layer forward engine: y[j] = sum_i x[i]*w[j][i] + b[j],
// with pipelined multiply, bias, ReLU, output saturation and start/done.
module forward_layer_mac #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 15,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 32,
    parameter int N_IN     = 784,
    parameter int N_OUT    = 16,
    parameter int MULT_LAT = 2
) (
    input logic clk,
    input logic rst,
    input logic en,
    forward_layer_mac_if.master bus
);
    localparam int XA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int J_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int D_W  = $clog2(MULT_LAT + 1);
    localparam int P_W  = 2 * DATA_W;

    localparam logic signed [ACC_W:0] OMAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OMIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [XA_W-1:0]  x_addr_q;
    logic [WA_W-1:0]  w_addr_q;
    logic [J_W-1:0]   j_q;
    logic [D_W-1:0]   d_q;
    logic             relu_q;
    logic             sat_q;
    logic             busy_q;
    logic             done_q;
    logic             ov_q;
    logic [OUT_W-1:0] od_q;
    logic [J_W-1:0]   oi_q;
    logic [ACC_W-1:0] acc_q;

    logic                rd_v_q;
    logic [MULT_LAT-1:0] pv_q;
    logic [P_W-1:0]      prod_q [MULT_LAT];

    logic [P_W-1:0]          xs, ws, mul;
    logic [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W:0]   acc_ext, bias_ext, sum, r;
    logic [OUT_W-1:0]        res;
    logic                    clip;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.start) state_d = ISSUE;
            ISSUE: if (x_addr_q == XA_W'(N_IN - 1)) state_d = DRAIN;
            DRAIN: if (d_q == D_W'(MULT_LAT)) state_d = OUT;
            OUT:   state_d = (j_q == J_W'(N_OUT - 1)) ? FIN : ISSUE;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xs = {{DATA_W{bus.x_data[DATA_W-1]}}, bus.x_data};
        ws = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
        mul = xs * ws;
        prod_ext = {{(ACC_W - P_W){prod_q[MULT_LAT-1][P_W-1]}},
                    prod_q[MULT_LAT-1]};
    end

    // Bias is aligned to the product scale (Q.2F) before the final shift.
    always_comb begin
        acc_ext  = {acc_q[ACC_W-1], acc_q};
        bias_ext = {{(ACC_W + 1 - DATA_W){bus.b_data[DATA_W-1]}}, bus.b_data};
        sum      = acc_ext + (bias_ext <<< FRAC_W);
        r        = sum >>> FRAC_W;
    end

    always_comb begin
        res  = r[OUT_W-1:0];
        clip = 1'b0;
        if (relu_q && r[ACC_W]) begin
            res = '0;
        end else if (r > OMAX) begin
            res  = OMAX[OUT_W-1:0];
            clip = 1'b1;
        end else if (r < OMIN) begin
            res  = OMIN[OUT_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_q <= 1'b0;
            pv_q   <= '0;
            for (int k = 0; k < MULT_LAT; k++) prod_q[k] <= '0;
        end else if (en) begin
            rd_v_q    <= (state_q == ISSUE);
            pv_q[0]   <= rd_v_q;
            prod_q[0] <= mul;
            for (int k = 1; k < MULT_LAT; k++) begin
                pv_q[k]   <= pv_q[k-1];
                prod_q[k] <= prod_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_addr_q <= '0;
            w_addr_q <= '0;
            j_q      <= '0;
            d_q      <= '0;
            relu_q   <= 1'b0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= '0;
            oi_q     <= '0;
            acc_q    <= '0;
        end else if (en) begin
            state_q <= state_d;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            if (pv_q[MULT_LAT-1]) acc_q <= acc_q + prod_ext;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        relu_q   <= bus.relu;
                        sat_q    <= 1'b0;
                        j_q      <= '0;
                        x_addr_q <= '0;
                        w_addr_q <= '0;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (x_addr_q != XA_W'(N_IN - 1)) begin
                        x_addr_q <= x_addr_q + XA_W'(1);
                        w_addr_q <= w_addr_q + WA_W'(1);
                    end
                end
                DRAIN: begin
                    d_q <= (d_q == D_W'(MULT_LAT)) ? '0 : d_q + D_W'(1);
                end
                OUT: begin
                    ov_q  <= 1'b1;
                    od_q  <= res;
                    oi_q  <= j_q;
                    acc_q <= '0;
                    if (clip) sat_q <= 1'b1;
                    if (j_q != J_W'(N_OUT - 1)) begin
                        j_q      <= j_q + J_W'(1);
                        x_addr_q <= '0;
                        w_addr_q <= w_addr_q + WA_W'(1);
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Pulses are held through en=0 cycles and shown only in an en=1 cycle.
    assign bus.done      = done_q & en;
    assign bus.out_valid = ov_q & en;
    assign bus.busy      = busy_q;
    assign bus.x_addr    = x_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = j_q;
    assign bus.out_data  = od_q;
    assign bus.out_idx   = oi_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: doc/forward_layer_mac.md
Name: forward_layer_mac

Overview:
- Parametrised fully-connected layer forward engine for the DBN datapath.
- For each of N_OUT neurons it computes y[j] = sum_i x[i]*w[j][i] + b[j] in signed fixed point.
- x, w and b are read from external synchronous memories.
- Each result is emitted on a valid-strobed output port, which feeds the next layer's input buffer.
- Successor to the single-neuron batch MAC: adds channel count, depth, latency and output-width parameters, bias, ReLU mode, saturation and a start/busy/done handshake.

Parameters:
- DATA_W, 16: width of x, w, b (signed, Q1.(DATA_W-1)).
- FRAC_W, 15: fractional bits of x, w, b and of out_data.
- ACC_W, 40: accumulator width (signed).
- OUT_W, 32: out_data width (signed).
- N_IN, 784: inputs per neuron.
- N_OUT, 16: neurons per layer.
- MULT_LAT, 2: multiplier pipeline latency in cycles (>=1).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: global advance enable; when 0, all state holds.
- start, input, 1: begin layer pass; sampled only in IDLE.
- relu, input, 1: 1 = ReLU output mode, 0 = linear; sampled with start.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse at end of layer.
- x_addr, output, $clog2(N_IN): input memory address.
- x_data, input, DATA_W: input memory read data.
- w_addr, output, $clog2(N_IN*N_OUT): weight address, j*N_IN+i.
- w_data, input, DATA_W: weight read data.
- b_addr, output, $clog2(N_OUT): bias address, j.
- b_data, input, DATA_W: bias read data.
- out_valid, output, 1: out_data/out_idx valid this cycle.
- out_data, output, OUT_W: neuron result.
- out_idx, output, $clog2(N_OUT): neuron index j of out_data.
- sat_flag, output, 1: sticky; set if any result saturated during current pass.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. busy, done, out_valid, out_data, out_idx, sat_flag, all addresses, accumulator and pipeline valid bits = 0.
  - Reset mid-pass aborts immediately; no further out_valid or done for that pass.
- Memories: read latency exactly 1 cycle (address at edge t, data valid during cycle t+1). The memories hold data while the address is held.
- en=0: every register holds, including FSM, counters, addresses and pipeline.
  - out_valid and done are asserted only in cycles with en=1; each pulse occupies exactly one en=1 cycle.
- FSM:
  - IDLE: start=1 & en=1 -> ISSUE. Latch relu, clear sat_flag, set j=0, i=0, acc=0.
  - ISSUE: one (x_addr=i, w_addr=j*N_IN+i) pair per cycle for i=0..N_IN-1. b_addr=j is held throughout the neuron. After i=N_IN-1 -> DRAIN.
  - DRAIN: 1+MULT_LAT cycles, until the last product is accumulated -> OUT.
  - OUT: one cycle.
    - Compute r = (acc + (sign-extended b_data << FRAC_W)) >>> FRAC_W (arithmetic shift, truncate toward minus infinity).
    - Saturate r to signed OUT_W range; set sat_flag on clamp.
    - If relu and r<0, output 0 (no sat_flag from ReLU).
    - out_valid=1 with out_idx=j; acc cleared.
    - If j<N_OUT-1: j++, i=0 -> ISSUE. Else -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Arithmetic:
  - Product = signed DATA_W x DATA_W -> 2*DATA_W, sign-extended to ACC_W. No intermediate truncation.
  - Accumulator wraps modulo 2^ACC_W; default sizing makes overflow impossible for N_IN<=256 at full scale.
- Timing: with start accepted at cycle 0, out_valid for neuron j occurs at cycle (j+1)*(N_IN+MULT_LAT+2), with en held 1. done occurs one cycle after the last out_valid.
- start while busy is ignored. out_data and out_idx hold their last values between pulses.
- N_IN=1 and N_OUT=1 are legal.

Test Plan:
- N_IN=4, N_OUT=2, MULT_LAT=2, all x=0x4000, w=0x4000, b=0, relu=0 -> out_valid at cycles 8 and 16; out_data=0x00008000; out_idx 0 then 1; done at cycle 17; sat_flag=0.
- Same, but w row 1 = 0xC000 -> neuron 1 out_data=0xFFFF8000 linear; with relu=1, out_data=0x00000000.
- Bias b[0]=0x2000, x=w=0 -> out_data=0x00002000.
- OUT_W=16, x=w=0x4000, b=0 -> out_data clamps to 0x7FFF and sat_flag=1. A subsequent start clears sat_flag.
- en toggled 0/1 every other cycle during a pass -> results identical to the first scenario; each out_valid lasts one en=1 cycle; total time doubles.
- rst=1 pulsed during DRAIN of neuron 0 -> all outputs 0 next cycle, no out_valid or done. A new start then yields the normal first-scenario sequence; start pulsed while busy -> ignored.
